// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StDone   = 2'b10
  } state_e;

  localparam logic PortCpu = 1'b0;
  localparam logic PortLdr = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational two-requester round-robin selector with a port-1 lock.
module mem_arbiter_rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  input  logic lock1_i,
  output logic winner_o,
  output logic any_o
);

  // On a tie the port not served last wins, unless port 1 was last and holds the lock.
  always_comb begin
    any_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      if (last_i == PortCpu) begin
        winner_o = PortLdr;
      end else begin
        winner_o = lock1_i ? PortLdr : PortCpu;
      end
    end else begin
      winner_o = req1_i ? PortLdr : PortCpu;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes CPU (port 0) and loader (port 1) accesses onto one synchronous-read memory.
module mem_arbiter #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req0_i,
  input  logic                 req1_i,
  input  logic                 wr0_i,
  input  logic                 wr1_i,
  input  logic [AddrWidth-1:0] addr0_i,
  input  logic [AddrWidth-1:0] addr1_i,
  input  logic [DataWidth-1:0] wdata0_i,
  input  logic [DataWidth-1:0] wdata1_i,
  input  logic                 lock1_i,
  output logic                 gnt0_o,
  output logic                 gnt1_o,
  output logic                 ack0_o,
  output logic                 ack1_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 busy_o,
  output logic                 mem_en_o,
  output logic                 mem_wr_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_din_o,
  input  logic [DataWidth-1:0] mem_dout_i
);

  import mem_arbiter_pkg::*;

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic                 wr_q, wr_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;

  logic pick_winner;
  logic pick_any;

  mem_arbiter_rr_pick u_rr_pick (
    .req0_i   (req0_i),
    .req1_i   (req1_i),
    .last_i   (last_q),
    .lock1_i  (lock1_i),
    .winner_o (pick_winner),
    .any_o    (pick_any)
  );

  // State, owner and request latches; last-served resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      owner_q <= PortCpu;
      last_q  <= PortLdr;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state: arbitrate and latch in IDLE, one ACCESS cycle, one DONE cycle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StAccess;
          owner_d = pick_winner;
          wr_d    = (pick_winner == PortLdr) ? wr1_i    : wr0_i;
          addr_d  = (pick_winner == PortLdr) ? addr1_i  : addr0_i;
          wdata_d = (pick_winner == PortLdr) ? wdata1_i : wdata0_i;
        end
      end
      StAccess: state_d = StDone;
      StDone: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode; everything derives from registered state so outputs are glitch-free of inputs
  // except the read-data pass-through in DONE.
  always_comb begin
    mem_en_o   = 1'b0;
    mem_wr_o   = 1'b0;
    mem_addr_o = '0;
    mem_din_o  = '0;
    ack0_o     = 1'b0;
    ack1_o     = 1'b0;
    rdata_o    = '0;
    busy_o     = (state_q != StIdle);
    gnt0_o     = ((state_q == StAccess) || (state_q == StDone)) && (owner_q == PortCpu);
    gnt1_o     = ((state_q == StAccess) || (state_q == StDone)) && (owner_q == PortLdr);
    case (state_q)
      StAccess: begin
        mem_en_o   = 1'b1;
        mem_wr_o   = wr_q;
        mem_addr_o = addr_q;
        mem_din_o  = wdata_q;
      end
      StDone: begin
        ack0_o  = (owner_q == PortCpu);
        ack1_o  = (owner_q == PortLdr);
        rdata_o = mem_dout_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: transaction-level reference model plus directed literal checks.
module tb_mem_arbiter;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          req0, req1, wr0, wr1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wd0, wd1;
  logic          gnt0, gnt1, ack0, ack1, busy, mem_en, mem_wr;
  logic [DW-1:0] rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;
  logic          mem_clr;

  always #5 clk = ~clk;

  mem_arbiter #(
    .DataWidth (DW),
    .AddrWidth (AW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .req0_i     (req0),
    .req1_i     (req1),
    .wr0_i      (wr0),
    .wr1_i      (wr1),
    .addr0_i    (addr0),
    .addr1_i    (addr1),
    .wdata0_i   (wd0),
    .wdata1_i   (wd1),
    .lock1_i    (lock1),
    .gnt0_o     (gnt0),
    .gnt1_o     (gnt1),
    .ack0_o     (ack0),
    .ack1_o     (ack1),
    .rdata_o    (rdata),
    .busy_o     (busy),
    .mem_en_o   (mem_en),
    .mem_wr_o   (mem_wr),
    .mem_addr_o (mem_addr),
    .mem_din_o  (mem_din),
    .mem_dout_i (mem_dout)
  );

  // Synchronous-read memory macro
  logic [DW-1:0] mem_arr [256];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= '0;
      mem_dout <= '0;
    end else if (mem_en) begin
      if (mem_wr) mem_arr[mem_addr] <= mem_din;
      else        mem_dout <= mem_arr[mem_addr];
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: a transaction started at an IDLE sampling edge occupies the next two cycles
  // (memory access, then acknowledge); m_age is the cycle index within that transaction.
  int            m_age;
  logic          m_own, m_wr, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] ref_mem [256];

  task automatic model_reset();
    m_age  = 0;
    m_last = 1'b1;
    m_own  = 1'b0;
    m_wr   = 1'b0;
    m_addr = '0;
    m_wd   = '0;
  endtask

  task automatic model_step();
    if (m_age == 0) begin
      if (req0 || req1) begin
        if (req0 && req1) m_own = (m_last == 1'b0) ? 1'b1 : lock1;
        else              m_own = req1;
        m_wr   = m_own ? wr1   : wr0;
        m_addr = m_own ? addr1 : addr0;
        m_wd   = m_own ? wd1   : wd0;
        m_age  = 1;
      end
    end else if (m_age == 1) begin
      if (m_wr) ref_mem[m_addr] = m_wd;
      m_age = 2;
    end else begin
      m_last = m_own;
      m_age  = 0;
    end
  endtask

  task automatic compare();
    bit acc, dn;
    acc = (m_age == 1);
    dn  = (m_age == 2);
    check("busy",     32'(busy),     32'(m_age != 0));
    check("gnt0",     32'(gnt0),     32'(m_age != 0 && !m_own));
    check("gnt1",     32'(gnt1),     32'(m_age != 0 && m_own));
    check("ack0",     32'(ack0),     32'(dn && !m_own));
    check("ack1",     32'(ack1),     32'(dn && m_own));
    check("mem_en",   32'(mem_en),   32'(acc));
    check("mem_wr",   32'(mem_wr),   32'(acc && m_wr));
    check("mem_addr", 32'(mem_addr), acc ? 32'(m_addr) : 32'd0);
    check("mem_din",  32'(mem_din),  acc ? 32'(m_wd) : 32'd0);
    if (!(dn && m_wr)) check("rdata", 32'(rdata), dn ? 32'(ref_mem[m_addr]) : 32'd0);
  endtask

  logic dut_own [$];
  int   ack_cyc [$];

  // One clock: advance model at the edge, compare on the falling edge, log observed acks.
  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    compare();
    if (ack0 || ack1) begin
      dut_own.push_back(ack1);
      ack_cyc.push_back(cyc);
    end
  endtask

  bit   pend0, pend1, drop0, drop1;
  logic exp_alt [4];
  logic exp_lck [5];

  initial begin
    rst_ni = 1'b0; mem_clr = 1'b1;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
    pend0 = 0; pend1 = 0; drop0 = 0; drop1 = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("rst_ack", 32'({ack0, ack1}), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    rst_ni = 1'b1; mem_clr = 1'b0;

    // Write 0x1234 to 0x10, then read it back
    req0 = 1; wr0 = 1; addr0 = 8'h10; wd0 = 16'h1234;
    tick(); tick();
    check("t1_wr_ack0", 32'(ack0), 32'd1);
    req0 = 0; wr0 = 0;
    tick();
    req0 = 1; addr0 = 8'h10;
    tick();
    check("t1_en_c1", 32'(mem_en), 32'd1);
    tick();
    check("t1_en_c2", 32'(mem_en), 32'd0);
    check("t1_ack0", 32'(ack0), 32'd1);
    check("t1_rdata", 32'(rdata), 32'h1234);
    check("t1_gnt1", 32'({gnt1, ack1}), 32'd0);
    req0 = 0;
    tick();

    // Loader writes 0xBEEF to 0x20
    req1 = 1; wr1 = 1; addr1 = 8'h20; wd1 = 16'hBEEF;
    tick(); tick();
    check("t2_ack1", 32'(ack1), 32'd1);
    req1 = 0; wr1 = 0;
    tick();

    // CPU reads 0x20 and drops its request during ACCESS
    req0 = 1; addr0 = 8'h20;
    tick();
    req0 = 0;
    tick();
    check("t3_ack0", 32'(ack0), 32'd1);
    check("t3_rdata", 32'(rdata), 32'hBEEF);
    repeat (3) begin
      tick();
      check("t3_idle", 32'(busy), 32'd0);
    end

    // Reset during ACCESS of a CPU write to 0x30
    req0 = 1; wr0 = 1; addr0 = 8'h30; wd0 = 16'hAAAA;
    tick();
    check("t4_in_access", 32'(mem_en), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("t4_rst_outs", 32'({gnt0, gnt1, ack0, ack1, busy, mem_en, mem_wr}), 32'd0);
    check("t4_rst_bus", 32'({mem_addr, mem_din, rdata}), 32'd0);
    model_reset();
    req0 = 0; wr0 = 0;
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    compare();
    tick(); tick();
    check("t4_mem30", 32'(mem_arr[8'h30]), 32'd0);

    // Both ports requesting continuously after reset: strict alternation
    dut_own.delete(); ack_cyc.delete();
    req0 = 1; req1 = 1; addr0 = 8'h10; addr1 = 8'h20; lock1 = 0;
    repeat (12) tick();
    req0 = 0; req1 = 0;
    exp_alt = '{1'b0, 1'b1, 1'b0, 1'b1};
    check("t5_count", 32'(dut_own.size()), 32'd4);
    for (int i = 0; i < dut_own.size() && i < 4; i++) check("t5_owner", 32'(dut_own[i]), 32'(exp_alt[i]));
    for (int i = 1; i < ack_cyc.size(); i++) check("t5_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);

    // Lock after a port-1 grant keeps port 1; port 0 wins once the lock drops
    dut_own.delete(); ack_cyc.delete();
    req0 = 1; req1 = 1; lock1 = 1;
    repeat (12) tick();
    lock1 = 0;
    repeat (3) tick();
    req0 = 0; req1 = 0;
    exp_lck = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    check("t6_count", 32'(dut_own.size()), 32'd5);
    for (int i = 0; i < dut_own.size() && i < 5; i++) check("t6_owner", 32'(dut_own[i]), 32'(exp_lck[i]));
    tick(); tick();

    // Randomized requesters that hold until acknowledged, occasionally dropping during ACCESS
    for (int n = 0; n < 3000; n++) begin
      if (m_age == 2) begin
        if (!m_own) begin pend0 = 0; drop0 = 0; end
        else        begin pend1 = 0; drop1 = 0; end
      end
      if (!pend0 && $urandom_range(0, 1) == 1) begin
        pend0 = 1; wr0 = 1'($urandom_range(0, 1));
        addr0 = 8'(8'h40 + $urandom_range(0, 7)); wd0 = 16'($urandom);
      end
      if (!pend1 && $urandom_range(0, 1) == 1) begin
        pend1 = 1; wr1 = 1'($urandom_range(0, 1));
        addr1 = 8'(8'h40 + $urandom_range(0, 7)); wd1 = 16'($urandom);
      end
      if (pend0 && m_age == 1 && !m_own && $urandom_range(0, 4) == 0) drop0 = 1;
      if (pend1 && m_age == 1 && m_own && $urandom_range(0, 4) == 0) drop1 = 1;
      req0 = pend0 && !drop0;
      req1 = pend1 && !drop1;
      if ($urandom_range(0, 3) == 0) lock1 = ~lock1;
      tick();
    end
    req0 = 0; req1 = 0; lock1 = 0;
    repeat (4) tick();
    check("end_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
